// File: rtl/branch_target_unit_if.sv
// Bus between the branch target unit and its neighbours.
// The master drives decode/LUT-write inputs; the slave returns fetch controls.
interface branch_target_unit_if #(
    parameter int T     = 10,
    parameter int LUT_W = 5
);
    logic [2:0]       Op;
    logic [LUT_W-1:0] LutIdx;
    logic [T-1:0]     ProgCtr;
    logic             LutWe;
    logic [LUT_W-1:0] LutWAddr;
    logic [T-1:0]     LutWData;
    logic [T-1:0]     Target;
    logic             BranchAbs;
    logic             BranchRelEn;
    logic             StackEmpty;
    logic             StackFull;
    logic             StackErr;

    modport master (
        output Op, LutIdx, ProgCtr,
        output LutWe, LutWAddr, LutWData,
        input  Target, BranchAbs, BranchRelEn,
        input  StackEmpty, StackFull, StackErr
    );

    modport slave (
        input  Op, LutIdx, ProgCtr,
        input  LutWe, LutWAddr, LutWData,
        output Target, BranchAbs, BranchRelEn,
        output StackEmpty, StackFull, StackErr
    );
endinterface

// File: rtl/branch_target_unit.sv
// Branch class decode, target LUT and hardware return-address stack
// feeding the instruction fetch unit.
module branch_target_unit #(
    parameter int T     = 10,
    parameter int LUT_W = 5,
    parameter int DEPTH = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    branch_target_unit_if.slave bus
);
    localparam int LUT_N = 1 << LUT_W;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    logic [T-1:0]  lut   [LUT_N];
    logic [T-1:0]  stack [DEPTH];
    logic [DW-1:0] depth;
    logic          err;

    logic          is_jmp;
    logic          is_brc;
    logic          is_call;
    logic          is_ret;
    logic          empty;
    logic          full;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] top_idx;
    logic [T-1:0]  lut_rd;
    logic [T-1:0]  ret_addr;

    assign is_jmp  = (bus.Op == 3'b001);
    assign is_brc  = (bus.Op == 3'b010);
    assign is_call = (bus.Op == 3'b011);
    assign is_ret  = (bus.Op == 3'b100);

    assign empty    = (depth == '0);
    assign full     = (depth == DEPTH_MAX);
    assign push_idx = depth[AW-1:0];
    assign top_idx  = AW'(depth - DW'(1));
    assign lut_rd   = lut[bus.LutIdx];
    assign ret_addr = bus.ProgCtr + T'(1);

    always_comb begin
        bus.Target      = '0;
        bus.BranchAbs   = 1'b0;
        bus.BranchRelEn = 1'b0;
        if (!Start) begin
            unique case (1'b1)
                is_jmp, is_call: begin
                    bus.BranchAbs = 1'b1;
                    bus.Target    = lut_rd;
                end
                is_brc: begin
                    bus.BranchRelEn = 1'b1;
                    bus.Target      = lut_rd;
                end
                is_ret: begin
                    // underflow falls through: fetch just increments
                    if (!empty) begin
                        bus.BranchAbs = 1'b1;
                        bus.Target    = stack[top_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.StackEmpty = empty;
    assign bus.StackFull  = full;
    assign bus.StackErr   = err;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            depth <= '0;
            err   <= 1'b0;
        end else if (Start) begin
            depth <= '0;
            err   <= 1'b0;
        end else if (is_call) begin
            if (full) begin
                err <= 1'b1;
            end else begin
                depth <= depth + DW'(1);
            end
        end else if (is_ret) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                depth <= depth - DW'(1);
            end
        end
    end

    // entry contents are don't-care after reset; only depth matters
    always_ff @(posedge Clk) begin
        if (Reset && !Start && is_call && !full) begin
            stack[push_idx] <= ret_addr;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else if (bus.LutWe) begin
            lut[bus.LutWAddr] <= bus.LutWData;
        end
    end
endmodule

// File: tb/tb_branch_target_unit.sv
// Randomized and directed checks of branch_target_unit against a
// queue-based model of the LUT and return stack.
module tb_branch_target_unit;
    localparam int T     = 10;
    localparam int LUT_W = 5;
    localparam int DEPTH = 4;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] BRC  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;

    logic Clk = 1'b0;
    logic Reset;
    logic Start;

    branch_target_unit_if #(.T(T), .LUT_W(LUT_W)) bus ();

    branch_target_unit #(.T(T), .LUT_W(LUT_W), .DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int vectors    = 0;
    int miscompares = 0;

    int m_lut [1 << LUT_W];
    int m_stk [$];
    bit m_err;

    logic [2:0] m_op;
    int         m_idx, m_pc, m_wa, m_wd;
    bit         m_we, m_st;

    function automatic logic [14:0] observed();
        return {bus.Target, bus.BranchAbs, bus.BranchRelEn,
                bus.StackEmpty, bus.StackFull, bus.StackErr};
    endfunction

    function automatic logic [14:0] exp_out();
        int  t = 0;
        bit  a = 0;
        bit  r = 0;
        if (!m_st) begin
            case (m_op)
                JMP, CALL: begin a = 1; t = m_lut[m_idx]; end
                BRC:       begin r = 1; t = m_lut[m_idx]; end
                RET: if (m_stk.size() > 0) begin
                    a = 1;
                    t = m_stk[$];
                end
                default: ;
            endcase
        end
        return {t[9:0], a, r, m_stk.size() == 0,
                m_stk.size() == DEPTH, m_err};
    endfunction

    function automatic void model_reset();
        foreach (m_lut[i]) m_lut[i] = 0;
        m_stk.delete();
        m_err = 0;
    endfunction

    task automatic apply(input logic [2:0] op, input int idx, input int pc,
                         input bit we = 0, input int wa = 0,
                         input int wd = 0, input bit st = 0);
        m_op = op; m_idx = idx; m_pc = pc;
        m_we = we; m_wa = wa; m_wd = wd; m_st = st;
        bus.Op       = op;
        bus.LutIdx   = LUT_W'(idx);
        bus.ProgCtr  = T'(pc);
        bus.LutWe    = we;
        bus.LutWAddr = LUT_W'(wa);
        bus.LutWData = T'(wd);
        Start        = st;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset) begin
            if (m_st) begin
                m_stk.delete();
                m_err = 0;
            end else if (m_op == CALL) begin
                if (m_stk.size() == DEPTH) m_err = 1;
                else m_stk.push_back((m_pc + 1) % (1 << T));
            end else if (m_op == RET) begin
                if (m_stk.size() == 0) m_err = 1;
                else void'(m_stk.pop_back());
            end
            if (m_we) m_lut[m_wa] = m_wd;
        end
        @(negedge Clk);
    endtask

    task automatic clear_stack();
        apply(NOP, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        model_reset();
        apply(JMP, 3, 0);
        vectors++;
        if (observed() !== exp_out()) begin
            miscompares++;
            $display("FAIL reset_state got=%h want=%h", observed(), exp_out());
        end
        tick();
        Reset = 1'b1;
        apply(JMP, 3, 0, 1, 3, 'h155);
        vectors++;
        if (bus.Target !== 10'h000) begin
            miscompares++;
            $display("FAIL lut_old_read got=%h want=000", bus.Target);
        end
        tick();
        apply(JMP, 3, 0);
        vectors++;
        if (bus.Target !== 10'h155 || bus.BranchAbs !== 1'b1 ||
            bus.BranchRelEn !== 1'b0 || bus.StackEmpty !== 1'b1) begin
            miscompares++;
            $display("FAIL lut_jmp got=%h want=%h", observed(), exp_out());
        end
        tick();
    endtask

    task automatic test_brc();
        apply(NOP, 0, 0, 1, 1, 'h3FE);
        tick();
        apply(BRC, 1, 0);
        vectors++;
        if (bus.Target !== 10'h3FE || bus.BranchRelEn !== 1'b1 ||
            bus.BranchAbs !== 1'b0) begin
            miscompares++;
            $display("FAIL brc got=%h want=%h", observed(), exp_out());
        end
        tick();
    endtask

    task automatic test_call_ret();
        logic [9:0] want_t [2];
        want_t[0] = 10'd41;
        want_t[1] = 10'd8;
        clear_stack();
        apply(NOP, 0, 0, 1, 2, 40);
        tick();
        apply(CALL, 2, 7);
        tick();
        apply(CALL, 2, 40);
        tick();
        vectors++;
        if (bus.StackFull !== 1'b0 || bus.StackEmpty !== 1'b0) begin
            miscompares++;
            $display("FAIL call_depth got=%h want=%h", observed(), exp_out());
        end
        for (int i = 0; i < 2; i++) begin
            apply(RET, 0, 0);
            vectors++;
            if (bus.Target !== want_t[i] || bus.BranchAbs !== 1'b1 ||
                bus.StackErr !== 1'b0) begin
                miscompares++;
                $display("FAIL ret_%0d got=%h want=%h", i, bus.Target, want_t[i]);
            end
            tick();
        end
        vectors++;
        if (bus.StackEmpty !== 1'b1 || bus.StackErr !== 1'b0) begin
            miscompares++;
            $display("FAIL call_ret_end got=%h want=%h", observed(), exp_out());
        end
    endtask

    task automatic test_overflow();
        clear_stack();
        for (int i = 0; i < 5; i++) begin
            apply(CALL, $urandom_range(31), $urandom_range(1023));
            vectors++;
            if (observed() !== exp_out() || bus.BranchAbs !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_call_%0d got=%h want=%h", i, observed(), exp_out());
            end
            tick();
        end
        vectors++;
        if (bus.StackFull !== 1'b1 || bus.StackErr !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flags got=%h want=%h", observed(), exp_out());
        end
        for (int i = 0; i < 5; i++) begin
            apply(RET, 0, 0);
            vectors++;
            if (observed() !== exp_out()) begin
                miscompares++;
                $display("FAIL ovf_ret_%0d got=%h want=%h", i, observed(), exp_out());
            end
            tick();
        end
        apply(RET, 0, 0);
        vectors++;
        if (bus.BranchAbs !== 1'b0 || bus.Target !== 10'h000) begin
            miscompares++;
            $display("FAIL underflow got=%h want=%h", observed(), exp_out());
        end
        tick();
    endtask

    task automatic test_wrap();
        clear_stack();
        apply(CALL, 2, 'h3FF);
        tick();
        apply(RET, 0, 0);
        vectors++;
        if (bus.Target !== 10'h000 || bus.BranchAbs !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap got=%h want=000", bus.Target);
        end
        tick();
    endtask

    task automatic test_start();
        clear_stack();
        apply(RET, 0, 0);
        tick();
        apply(CALL, 2, 100);
        tick();
        apply(CALL, 2, 200);
        tick();
        apply(JMP, 3, 0, 0, 0, 0, 1);
        vectors++;
        if (observed() !== exp_out() || bus.BranchAbs !== 1'b0) begin
            miscompares++;
            $display("FAIL start_force got=%h want=%h", observed(), exp_out());
        end
        tick();
        apply(JMP, 3, 0);
        vectors++;
        if (bus.StackEmpty !== 1'b1 || bus.StackErr !== 1'b0 ||
            bus.Target !== 10'h155) begin
            miscompares++;
            $display("FAIL start_clear got=%h want=%h", observed(), exp_out());
        end
        tick();
    endtask

    task automatic test_async_reset();
        apply(CALL, 3, 50);
        tick();
        apply(CALL, 3, 60);
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (observed() !== exp_out() || bus.Target !== 10'h000 ||
            bus.StackEmpty !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset got=%h want=%h", observed(), exp_out());
        end
        tick();
        Reset = 1'b1;
        apply(JMP, 3, 0);
        vectors++;
        if (bus.Target !== 10'h000) begin
            miscompares++;
            $display("FAIL lut_cleared got=%h want=000", bus.Target);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(3'($urandom_range(7)), $urandom_range(31), $urandom_range(1023),
                  $urandom_range(3) == 0, $urandom_range(31),
                  $urandom_range(1023), $urandom_range(15) == 0);
            vectors++;
            if (observed() !== exp_out() ||
                (bus.BranchAbs === 1'b1 && bus.BranchRelEn === 1'b1)) begin
                miscompares++;
                $display("FAIL rand_%0d op=%0d got=%h want=%h",
                         i, m_op, observed(), exp_out());
            end
            tick();
        end
    endtask

    initial begin
        Start = 1'b0;
        test_reset();
        test_brc();
        test_call_ret();
        test_overflow();
        test_wrap();
        test_start();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
